up4_core: RTL and testbench
===========================

# up4_core

Parametrised accumulator processor core, successor to the 8-bit externally sequenced datapath. It folds the PC, IR, AC, ALU, address mux and an internal fetch/decode/execute controller into one block. It is generic in data and address width and drives a single-port synchronous RAM with one-cycle read latency. It adds a run gate, conditional branches, halt and, optionally, indirect addressing.

## Interface
- DATA_W, 8, AC/memory word width; must be ≥ 5
- ADDR_W, 8, PC/memory address width; must be ≤ DATA_W
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  when 0, core freezes: no state/register change, mem_we forced 0
- mem_addr  out  ADDR_W  RAM address (combinational from state)
- mem_wdata  out  DATA_W  RAM write data (= AC)
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_addr is presented
- pc  out  ADDR_W  program counter
- opcode  out  DATA_W  instruction word 0 (IRU)
- value  out  DATA_W  instruction word 1 (IRL)
- acc  out  DATA_W  accumulator
- zflg, nflg  out  1  zero/negative flags (registered)
- halted  out  1  high while in HALT

## Operation
- Instruction = two consecutive words: opcode word, then operand word. Opcode field = opcode[3:0]; opcode[4] = indirect bit (see Configuration); other bits ignored.
- Opcodes: 0 NOP; 1 LDI AC=value; 2 LDA AC=M[a]; 3 STA M[a]=AC; 4 ADD; 5 SUB (AC−M[a]); 6 AND; 7 OR; 8 JMP pc=a; 9 JZ if zflg; A JN if nflg; F HLT; B–E execute as NOP.
- a = value[ADDR_W-1:0] (effective address).
- States: F1, F2, F3, [IND], EX, WB, HALT.
  - F1: mem_addr=pc; pc<=pc+1.
  - F2: opcode<=mem_rdata; mem_addr=pc; pc<=pc+1.
  - F3: value<=mem_rdata. Go to IND if indirect applies, else EX.
  - EX:
    - LDI: AC<=value, go to F1.
    - JMP/JZ/JN: pc<=a if the condition is true, go to F1.
    - STA: mem_addr=a, mem_we=1, go to F1.
    - LDA/ALU ops: mem_addr=a, go to WB.
    - HLT: go to HALT.
    - NOP: go to F1.
  - WB: AC<=f(AC, mem_rdata), go to F1.
  - HALT: terminal until reset; halted=1; mem_we=0.
- Flags update only when AC is written (LDI, LDA, ALU ops): zflg = (new AC==0); nflg = new AC[DATA_W-1]. STA, jumps and NOP hold the flags.
- Arithmetic is modulo 2^DATA_W; no carry or overflow output.
- pc wraps from 2^ADDR_W−1 to 0, including mid-fetch (operand fetched from address 0).
- mem_addr outside memory states = pc; mem_wdata = AC at all times.

## Timing
- Reset (async assert, sync-clean deassert) values:
  - state=F1, pc=0, opcode=0, value=0, acc=0
  - zflg=0, nflg=0, halted=0, mem_we=0
- The first fetch presents address 0 on the first enabled edge after reset release.
- Cycles per instruction, run held at 1:
  - LDI/NOP/JMP/JZ/JN/STA: 4
  - LDA/ADD/SUB/AND/OR: 5
  - indirect form: +1
- run=0 in any state holds every register, including the RAM-latency pairing. When run rises in F2, F3, IND or WB, the RAM has kept the same address, so mem_rdata is still valid.
- JZ/JN sample the flags as they stand at EX, i.e. after the prior instruction's writeback.
- Reset asserted mid-instruction (including EX of STA) drops mem_we within the same cycle. No partial AC update.

## Configuration
- UP4_INDIRECT_EN defined:
  - When opcode[4]=1 on LDA, STA, ALU ops, JMP, JZ or JN, F3 is followed by IND.
  - IND: mem_addr=a; next cycle value<=mem_rdata; then EX uses the new value as the pointer target.
  - opcode[4] is ignored for LDI, NOP and HLT.
- Undefined: IND state absent; opcode[4] ignored everywhere; cycle counts as listed above.

## Test plan
- Reset, then run=1 with M[0..3]=01,2A,03,80 → after 8 cycles acc=0x2A, M[0x80]=0x2A, pc=4, zflg=0, nflg=0.
- LDI 0x05; SUB M[0x90]=0x05; JZ 0x20 → acc=0, zflg=1, pc=0x20 after the jump EX. Repeat with M[0x90]=0x06 → acc=0xFF, nflg=1, branch not taken, pc=6.
- DATA_W=12, ADDR_W=6: ADD of 0xFFF + 0x002 → acc=0x001 (wrap). An instruction placed at address 63 fetches its operand from address 0.
- Drop run to 0 for 3 cycles in F2 and again in WB of an ADD → identical final acc/pc to the uninterrupted run; mem_we never high while run=0.
- HLT (0x0F) → halted=1 and pc frozen for 10 cycles. Asserting reset low mid-STA EX → mem_we=0 immediately; all outputs at reset values.
- With UP4_INDIRECT_EN: M[0x40]=0x50, M[0x50]=0x77, LDA indirect (0x12, 0x40) → acc=0x77 after 6 cycles. Without the macro, the same program gives acc=0x50 after 5 cycles.

Source files
------------

// File: rtl/up4_core.sv
// up4_core -- parametrised accumulator processor core.
//
// Each instruction is two words: an opcode word followed by an operand word.
// The core drives a single-port synchronous RAM with one cycle of read
// latency. A fetch/decode/execute controller walks F1 -> F2 -> F3 -> EX,
// with an extra WB cycle for instructions that read memory into AC.
//
// run=0 freezes every register. While frozen the RAM address is held at the
// last address presented, so the RAM keeps returning the word the stalled
// state is waiting for.
//
// Optional feature: define UP4_INDIRECT_EN to enable indirect addressing
// (opcode bit 4) through an extra IND cycle. Without the macro, bit 4 is
// ignored and the IND state does not exist.
//
// Parameter constraints: DATA_W >= 5, ADDR_W <= DATA_W.

module up4_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] acc,
  output logic              zflg,
  output logic              nflg,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_F1   = 3'd0,
    S_F2   = 3'd1,
    S_F3   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
`ifdef UP4_INDIRECT_EN
    ,
    S_IND  = 3'd6
`endif
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDA = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_JMP = 4'h8,
    OP_JZ  = 4'h9,
    OP_JN  = 4'hA,
    OP_HLT = 4'hF
  } op_e;

  // Architectural and controller state
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] value_q;
  logic [DATA_W-1:0] acc_q;
  logic              zflg_q;
  logic              nflg_q;
  logic              halted_q;
  logic [ADDR_W-1:0] last_addr_q;   // address presented on the last enabled cycle
`ifdef UP4_INDIRECT_EN
  logic              ind_q;         // EX was entered through IND
  logic              ind_req;       // current instruction takes the IND detour
`endif

  // Decoded / next-state values
  op_e               op;
  logic              mem_op;        // EX addresses memory at the effective address
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] addr_live;
  logic [DATA_W-1:0] alu_d;
  logic              take_d;

  // Decode the instruction register and build the datapath results.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements leaves a value unassigned (no latches).
    op       = op_e'(opcode_q[3:0]);
    mem_op   = 1'b0;
    alu_d    = mem_rdata;
    take_d   = 1'b0;
    pc_inc   = pc_q + ADDR_W'(1);
`ifdef UP4_INDIRECT_EN
    // After IND, the pointer word is arriving on mem_rdata during EX.
    eff_addr = ind_q ? mem_rdata[ADDR_W-1:0] : value_q[ADDR_W-1:0];
    ind_req  = opcode_q[4] &&
               (op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_JMP, OP_JZ, OP_JN});
`else
    eff_addr = value_q[ADDR_W-1:0];
`endif

    case (op)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: mem_op = 1'b1;
      default:                                       mem_op = 1'b0;
    endcase

    // Writeback function; LDA passes the read word straight through.
    case (op)
      OP_ADD:  alu_d = acc_q + mem_rdata;
      OP_SUB:  alu_d = acc_q - mem_rdata;
      OP_AND:  alu_d = acc_q & mem_rdata;
      OP_OR:   alu_d = acc_q | mem_rdata;
      default: alu_d = mem_rdata;
    endcase

    // Branch conditions use the flags as they stand at EX.
    case (op)
      OP_JMP:  take_d = 1'b1;
      OP_JZ:   take_d = zflg_q;
      OP_JN:   take_d = nflg_q;
      default: take_d = 1'b0;
    endcase
  end

  // RAM address and write strobe, combinational from the current state.
  always_comb begin
    addr_live = pc_q;
    case (state_q)
      S_EX:    addr_live = mem_op ? eff_addr : pc_q;
`ifdef UP4_INDIRECT_EN
      S_IND:   addr_live = value_q[ADDR_W-1:0];
`endif
      default: addr_live = pc_q;
    endcase
    // Frozen: keep the RAM pointed at the word the stalled state expects.
    mem_addr = run ? addr_live : last_addr_q;
    mem_we   = run && (state_q == S_EX) && (op == OP_STA);
  end

  assign mem_wdata = acc_q;
  assign pc        = pc_q;
  assign opcode    = opcode_q;
  assign value     = value_q;
  assign acc       = acc_q;
  assign zflg      = zflg_q;
  assign nflg      = nflg_q;
  assign halted    = halted_q;

  // Fetch/decode/execute controller with all architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_F1;
      pc_q        <= '0;
      opcode_q    <= '0;
      value_q     <= '0;
      acc_q       <= '0;
      zflg_q      <= 1'b0;
      nflg_q      <= 1'b0;
      halted_q    <= 1'b0;
      last_addr_q <= '0;
`ifdef UP4_INDIRECT_EN
      ind_q       <= 1'b0;
`endif
    end else if (run) begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      last_addr_q <= addr_live;
      case (state_q)
        S_F1: begin
          pc_q    <= pc_inc;
          state_q <= S_F2;
        end
        S_F2: begin
          opcode_q <= mem_rdata;
          pc_q     <= pc_inc;
          state_q  <= S_F3;
        end
        S_F3: begin
          value_q <= mem_rdata;
`ifdef UP4_INDIRECT_EN
          ind_q   <= 1'b0;
          state_q <= ind_req ? S_IND : S_EX;
`else
          state_q <= S_EX;
`endif
        end
`ifdef UP4_INDIRECT_EN
        S_IND: begin
          ind_q   <= 1'b1;
          state_q <= S_EX;
        end
`endif
        S_EX: begin
`ifdef UP4_INDIRECT_EN
          // The pointer target replaces the operand word.
          if (ind_q) value_q <= mem_rdata;
          ind_q <= 1'b0;
`endif
          state_q <= S_F1;
          case (op)
            OP_LDI: begin
              acc_q  <= value_q;
              zflg_q <= (value_q == '0);
              nflg_q <= value_q[DATA_W-1];
            end
            OP_JMP, OP_JZ, OP_JN: begin
              if (take_d) pc_q <= eff_addr;
            end
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              state_q <= S_WB;
            end
            OP_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: ;  // NOP, STA (write strobe is combinational), B-E
          endcase
        end
        S_WB: begin
          acc_q   <= alu_d;
          zflg_q  <= (alu_d == '0);
          nflg_q  <= alu_d[DATA_W-1];
          state_q <= S_F1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_F1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up4_core.sv
// Testbench for up4_core. Two instances run side by side from one clock:
// an 8/8 core on a 256-word RAM and a 12/6 core on a 64-word RAM. Directed
// programs check fixed results; random memory images are executed by an
// instruction-level reference model and the cores are compared against it
// at the exact cycle where the model says the last instruction retires.
// Build with +define+UP4_INDIRECT_EN to match an indirect-enabled core.

module tb_up4_core;

  logic clk = 1'b0;
  logic reset;
  logic run;

  // 8/8 instance
  logic [7:0]  addr0, wdata0, rdata0, pc0, op0, val0, acc0;
  logic        we0, z0, n0, h0;
  // 12/6 instance
  logic [5:0]  addr1, pc1;
  logic [11:0] wdata1, rdata1, op1, val1, acc1;
  logic        we1, z1, n1, h1;

  logic [7:0]  mem0 [256];
  logic [11:0] mem1 [64];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int img [256];
  int n_chk = 0;
  int n_err = 0;
  int we_viol = 0;

  // Reference model state, index 0 = 8/8 core, 1 = 12/6 core
  int mm [2][256];
  int m_pc [2], m_acc [2], m_op [2], m_val [2];
  bit m_z [2], m_n [2], m_h [2];

  up4_core #(.DATA_W(8), .ADDR_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0), .mem_rdata(rdata0),
    .pc(pc0), .opcode(op0), .value(val0), .acc(acc0),
    .zflg(z0), .nflg(n0), .halted(h0)
  );

  up4_core #(.DATA_W(12), .ADDR_W(6)) u_dut1 (
    .clk(clk), .reset(reset), .run(run),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1), .mem_rdata(rdata1),
    .pc(pc1), .opcode(op1), .value(val1), .acc(acc1),
    .zflg(z1), .nflg(n1), .halted(h1)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAMs with a bench-side load port.
  always @(posedge clk) begin
    if (ld_en) mem0[ld_addr] <= ld_data[7:0];
    else if (we0) mem0[addr0] <= wdata0;
    rdata0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_addr < 8'd64) mem1[ld_addr[5:0]] <= ld_data[11:0];
    end else if (we1) begin
      mem1[addr1] <= wdata1;
    end
    rdata1 <= mem1[addr1];
  end

  // A write strobe while frozen is never allowed.
  always @(negedge clk) begin
    if (!run && (we0 || we1)) we_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 0;
  endtask

  // Hold reset, load img into both RAMs and the model, then release.
  task automatic do_reset_load();
    reset = 1'b0;
    run   = 1'b0;
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_addr = 8'(i);
      ld_data = img[i];
      tick();
    end
    ld_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mm[0][i] = img[i] & 32'hFF;
      mm[1][i] = (i < 64) ? (img[i] & 32'hFFF) : 0;
    end
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_acc[k] = 0; m_op[k] = 0; m_val[k] = 0;
      m_z[k] = 1'b0; m_n[k] = 1'b0; m_h[k] = 1'b0;
    end
    tick();
    reset = 1'b1;
    run   = 1'b1;
  endtask

  function automatic int dw_of(input int k);
    return (k == 0) ? 8 : 12;
  endfunction

  function automatic int aw_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic model_wr_acc(input int k, input int x);
    m_acc[k] = x & ((1 << dw_of(k)) - 1);
    m_z[k]   = (m_acc[k] == 0);
    m_n[k]   = ((m_acc[k] >> (dw_of(k) - 1)) & 1) == 1;
  endtask

  // Execute one instruction at the architectural level; returns its cycles.
  task automatic model_step(input int k, output int cyc);
    int md, ma, opw, f, a, v;
    bit ind;
    md  = (1 << dw_of(k)) - 1;
    ma  = (1 << aw_of(k)) - 1;
    cyc = 0;
    if (m_h[k]) return;
    opw = mm[k][m_pc[k]];
    m_pc[k] = (m_pc[k] + 1) & ma;
    v = mm[k][m_pc[k]];
    m_pc[k] = (m_pc[k] + 1) & ma;
    cyc = 4;
    f = opw & 15;
    ind = 1'b0;
`ifdef UP4_INDIRECT_EN
    ind = (((opw >> 4) & 1) == 1) && (f >= 2) && (f <= 10);
`endif
    a = v & ma;
    if (ind) begin
      v = mm[k][a];
      a = v & ma;
      cyc++;
    end
    m_op[k]  = opw;
    m_val[k] = v;
    case (f)
      1:  model_wr_acc(k, v);
      2:  begin model_wr_acc(k, mm[k][a]); cyc++; end
      3:  mm[k][a] = m_acc[k];
      4:  begin model_wr_acc(k, (m_acc[k] + mm[k][a]) & md); cyc++; end
      5:  begin model_wr_acc(k, (m_acc[k] - mm[k][a]) & md); cyc++; end
      6:  begin model_wr_acc(k, m_acc[k] & mm[k][a]); cyc++; end
      7:  begin model_wr_acc(k, m_acc[k] | mm[k][a]); cyc++; end
      8:  m_pc[k] = a;
      9:  if (m_z[k]) m_pc[k] = a;
      10: if (m_n[k]) m_pc[k] = a;
      15: m_h[k] = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_run(input int k, input int n_instr, output int total);
    int c;
    total = 0;
    for (int i = 0; i < n_instr; i++) begin
      model_step(k, c);
      total += c;
    end
  endtask

  task automatic check_dut(input int k);
    int diff;
    diff = 0;
    if (k == 0) begin
      check("acc8",   32'(acc0), m_acc[0]);
      check("pc8",    32'(pc0),  m_pc[0]);
      check("opc8",   32'(op0),  m_op[0]);
      check("val8",   32'(val0), m_val[0]);
      check("z8",     32'(z0),   32'(m_z[0]));
      check("n8",     32'(n0),   32'(m_n[0]));
      check("halt8",  32'(h0),   32'(m_h[0]));
      for (int i = 0; i < 256; i++) if ({24'd0, mem0[i]} != mm[0][i]) diff++;
      check("mem8_diff", diff, 0);
    end else begin
      check("acc12",  32'(acc1), m_acc[1]);
      check("pc12",   32'(pc1),  m_pc[1]);
      check("opc12",  32'(op1),  m_op[1]);
      check("val12",  32'(val1), m_val[1]);
      check("z12",    32'(z1),   32'(m_z[1]));
      check("n12",    32'(n1),   32'(m_n[1]));
      check("halt12", 32'(h1),   32'(m_h[1]));
      for (int i = 0; i < 64; i++) if ({20'd0, mem1[i]} != mm[1][i]) diff++;
      check("mem12_diff", diff, 0);
    end
  endtask

  // Run n_instr instructions on both cores. mode 0: run held high;
  // mode 1: random run gating; mode 2: 3-cycle stalls before enabled
  // edges 2 and 9 (F2 of the first instruction, WB of the second).
  task automatic run_prog(input int n_instr, input int mode);
    int c [2];
    bit done [2];
    int en, cyc, p1, p2;
    model_run(0, n_instr, c[0]);
    model_run(1, n_instr, c[1]);
    en = 0; cyc = 0; p1 = 0; p2 = 0;
    done[0] = 1'b0; done[1] = 1'b0;
    while (!(done[0] && done[1]) && (cyc < 8 * (c[0] + c[1]) + 64)) begin
      case (mode)
        1: run = ($urandom_range(0, 3) != 0);
        2: begin
          if (en == 1 && p1 < 3)      begin run = 1'b0; p1++; end
          else if (en == 8 && p2 < 3) begin run = 1'b0; p2++; end
          else                             run = 1'b1;
        end
        default: run = 1'b1;
      endcase
      tick();
      cyc++;
      if (run) en++;
      for (int k = 0; k < 2; k++) begin
        if (!done[k] && en == c[k]) begin
          check_dut(k);
          done[k] = 1'b1;
        end
      end
    end
    check("prog_done", {30'd0, done[1], done[0]}, 32'd3);
    run = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    run     = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (2) tick();

    // Reset values
    check("rst_acc",   32'(acc0),  0);
    check("rst_pc",    32'(pc0),   0);
    check("rst_opc",   32'(op0),   0);
    check("rst_val",   32'(val0),  0);
    check("rst_flags", {29'd0, z0, n0, h0}, 0);
    check("rst_we",    32'(we0 | we1), 0);
    check("rst_addr",  32'(addr0), 0);
    check("rst_acc12", 32'(acc1),  0);

    // LDI 0x2A; STA 0x80
    clear_img();
    img[0] = 'h01; img[1] = 'h2A; img[2] = 'h03; img[3] = 'h80;
    do_reset_load();
    repeat (8) tick();
    check("a_acc",  32'(acc0), 'h2A);
    check("a_mem",  32'(mem0[8'h80]), 'h2A);
    check("a_pc",   32'(pc0), 4);
    check("a_zn",   {30'd0, z0, n0}, 0);

    // LDI 5; SUB M[0x90]; JZ 0x20 with equal and larger subtrahend
    for (int r = 0; r < 2; r++) begin
      clear_img();
      img[0] = 'h01; img[1] = 'h05; img[2] = 'h05; img[3] = 'h90;
      img[4] = 'h09; img[5] = 'h20; img[8'h90] = (r == 0) ? 'h05 : 'h06;
      do_reset_load();
      repeat (13) tick();
      if (r == 0) begin
        check("jz_acc", 32'(acc0), 0);
        check("jz_z",   32'(z0), 1);
        check("jz_pc",  32'(pc0), 'h20);
      end else begin
        check("jn_acc", 32'(acc0), 'hFF);
        check("jn_nz",  {30'd0, n0, z0}, 2);
        check("jn_pc",  32'(pc0), 6);
      end
    end

    // 12/6 core: ADD wrap, then an instruction at 63 fetches its operand from 0
    clear_img();
    img[0] = 'h7C1; img[1] = 'hFFF; img[2] = 'h004; img[3] = 'h010;
    img[4] = 'h008; img[5] = 'h03F; img['h10] = 'h002; img[63] = 'h001;
    do_reset_load();
    repeat (9) tick();
    check("w_acc12", 32'(acc1), 'h001);
    check("w_zn12",  {30'd0, z1, n1}, 0);
    repeat (8) tick();
    check("wrap_acc12", 32'(acc1), 'h7C1);
    check("wrap_pc12",  32'(pc1), 1);

    // HLT freezes the core
    clear_img();
    img[0] = 'h0F;
    do_reset_load();
    repeat (4) tick();
    check("hlt_h",  32'(h0), 1);
    check("hlt_pc", 32'(pc0), 2);
    repeat (10) tick();
    check("hlt_pc_hold", 32'(pc0), 2);
    check("hlt_h_hold",  32'(h0), 1);

    // Reset asserted during EX of STA
    clear_img();
    img[0] = 'h01; img[1] = 'h33; img[2] = 'h03; img[3] = 'h81;
    do_reset_load();
    repeat (7) tick();
    check("sta_we",   32'(we0), 1);
    check("sta_addr", 32'(addr0), 'h81);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_we",  32'(we0), 0);
    check("rst_mid_acc", 32'(acc0), 0);
    check("rst_mid_pc",  32'(pc0), 0);
    check("rst_mid_ir",  {16'd0, op0, val0}, 0);
    tick();
    check("rst_mid_mem", 32'(mem0[8'h81]), 0);

    // Indirect LDA (0x12, 0x40)
    clear_img();
    img[0] = 'h12; img[1] = 'h40; img[2] = 'h0F; img['h40] = 'h50; img['h50] = 'h77;
    do_reset_load();
`ifdef UP4_INDIRECT_EN
    repeat (6) tick();
    check("ind_acc", 32'(acc0), 'h77);
`else
    repeat (5) tick();
    check("ind_acc", 32'(acc0), 'h50);
`endif

    // Stalls in F2 and in WB of an ADD give the uninterrupted result
    clear_img();
    img[0] = 'h01; img[1] = 'h05; img[2] = 'h04; img[3] = 'h90;
    img[4] = 'h0F; img['h90] = 'h07;
    do_reset_load();
    run_prog(3, 2);
    check("stall_acc", 32'(acc0), 'h0C);

    // Random memory images against the reference model
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 256; i++) img[i] = int'($urandom);
      do_reset_load();
      run_prog(int'($urandom_range(1, 24)), t % 2);
    end

    check("we_while_frozen", we_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
